// File: rtl/sad_min_select_if.sv
// Handshake bundle between the PE array front end and the motion-vector
// decision stage: SAD strobe inputs plus the search status/result outputs.
interface sad_min_select_if #(
  parameter int SAD_WIDTH = 14,
  parameter int MVW       = 5
);
  logic                 start;
  logic                 sad_valid;
  logic [SAD_WIDTH-1:0] sad;
  logic                 busy;
  logic                 done;
  logic [SAD_WIDTH-1:0] min_sad;
  logic [MVW-1:0]       mv_x;
  logic [MVW-1:0]       mv_y;

  modport master (
    output start, sad_valid, sad,
    input  busy, done, min_sad, mv_x, mv_y
  );

  modport slave (
    input  start, sad_valid, sad,
    output busy, done, min_sad, mv_x, mv_y
  );
endinterface

// File: rtl/sad_min_select.sv
// sad_min_select: tracks the minimum SAD and its candidate position over one
// block-matching search. Pipeline-fill strobes are skipped, row-wrap strobes
// (x >= NC) advance the raster but are never compared.
// Optional feature macro: ZERO_SAD_STOP_EN -- a zero-SAD candidate ends the
// search early.
module sad_min_select #(
  parameter int TB_LENGTH = 8,
  parameter int SW_LENGTH = 32,
  parameter int SAD_WIDTH = 14,
  parameter int SKIP_CNT  = SW_LENGTH * (TB_LENGTH - 1) + TB_LENGTH - 1
) (
  input logic              clk,
  input logic              rst_n,
  sad_min_select_if.slave  bus
);

  localparam int NC  = SW_LENGTH - TB_LENGTH + 1;
  localparam int MVW = $clog2(NC);
  localparam int XW  = $clog2(SW_LENGTH);
  localparam int SKW = (SKIP_CNT > 1) ? $clog2(SKIP_CNT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    SEARCH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SKW-1:0]       skip_q, skip_d;
  logic [XW-1:0]        x_q, x_d;
  logic [MVW-1:0]       y_q, y_d;
  logic [SAD_WIDTH-1:0] min_q, min_d;
  logic [MVW-1:0]       mvx_q, mvx_d;
  logic [MVW-1:0]       mvy_q, mvy_d;
  logic                 done_q, done_d;

  logic is_cand;
  logic is_last;
  logic zero_hit;

  // Raster position classification: real candidate and final candidate.
  assign is_cand = ({1'b0, x_q} < (XW + 1)'(NC));
  assign is_last = (x_q == XW'(NC - 1)) && (y_q == MVW'(NC - 1));

`ifdef ZERO_SAD_STOP_EN
  assign zero_hit = is_cand && (bus.sad == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: counters, running minimum, best position, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      min_q  <= '1;
      mvx_q  <= '0;
      mvy_q  <= '0;
      done_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
      x_q    <= x_d;
      y_q    <= y_d;
      min_q  <= min_d;
      mvx_q  <= mvx_d;
      mvy_q  <= mvy_d;
      done_q <= done_d;
    end
  end

  // Next-state and datapath update; start has priority and swallows a
  // coincident strobe.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d = state_q;
    skip_d  = skip_q;
    x_d     = x_q;
    y_d     = y_q;
    min_d   = min_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
    done_d  = 1'b0;

    if (bus.start) begin
      state_d = (SKIP_CNT == 0) ? SEARCH : SKIP;
      skip_d  = '0;
      x_d     = '0;
      y_d     = '0;
      min_d   = '1;
      mvx_d   = '0;
      mvy_d   = '0;
    end else if (bus.sad_valid) begin
      unique case (state_q)
        SKIP: begin
          if (skip_q == SKW'(SKIP_CNT - 1)) begin
            state_d = SEARCH;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + SKW'(1);
          end
        end
        SEARCH: begin
          if (is_cand && (bus.sad < min_q)) begin
            min_d = bus.sad;
            mvx_d = x_q[MVW-1:0];
            mvy_d = y_q;
          end
          if (x_q == XW'(SW_LENGTH - 1)) begin
            x_d = '0;
            y_d = y_q + MVW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (is_last || zero_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = done_q;
    bus.min_sad = min_q;
    bus.mv_x    = mvx_q;
    bus.mv_y    = mvy_q;
  end

endmodule

// File: tb/tb_sad_min_select.sv
// Directed self-checking bench for sad_min_select (default parameters).
module tb_sad_min_select;

  localparam int SADW  = 14;
  localparam int MVW   = 5;
  localparam int SW    = 32;
  localparam int NC    = 25;
  localparam int SKIP  = 231;
  localparam int NSRCH = 793;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sad_min_select_if #(.SAD_WIDTH(SADW), .MVW(MVW)) bus ();

  sad_min_select dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Strobes accepted since the last start, and done pulse bookkeeping.
  int n_str    = 0;
  int done_cnt = 0;
  int done_at  = -1;

  always @(posedge clk) begin
    if (!rst_n || bus.start) n_str <= 0;
    else if (bus.sad_valid)  n_str <= n_str + 1;
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_at = n_str;
    end
  end

  // Snapshot of the outputs in the cycle done was high.
  bit              saw_done;
  logic            snap_busy;
  logic [SADW-1:0] snap_min;
  logic [MVW-1:0]  snap_x, snap_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus, applied at the falling edge.
  task automatic drive(input logic st, input logic v, input logic [SADW-1:0] s);
    @(negedge clk);
    if (bus.done === 1'b1) begin
      saw_done  = 1'b1;
      snap_busy = bus.busy;
      snap_min  = bus.min_sad;
      snap_x    = bus.mv_x;
      snap_y    = bus.mv_y;
    end
    bus.start     = st;
    bus.sad_valid = v;
    bus.sad       = s;
  endtask

  task automatic gap(input int gapmax);
    if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) drive(1'b0, 1'b0, '0);
  endtask

  function automatic int sad_for(input int scen, input int x, input int y);
    case (scen)
      2: return (x == 3 && y == 5) ? 20 : 100;
      3: begin
        if (x == 28) return 0;
        if ((x == 10 && y == 2) || (x == 1 && y == 7)) return 50;
        return 60;
      end
      4: return (x == 4 && y == 4) ? 0 : 100;
      default: return 100;
    endcase
  endfunction

  // One search: start, fill strobes, then raster strobes until done, abort
  // point, or strobe budget. probe_k >= 0 checks min_sad right after that strobe.
  task automatic run_pass(input int scen, input int gapmax, input int abort_at,
                          input bit start_strobe, input int probe_k, input int probe_min);
    saw_done = 1'b0;
    drive(1'b1, start_strobe, '0);
    drive(1'b0, 1'b1, '0);
    check("busy_after_start", bus.busy, 1);
    check("min_after_start", bus.min_sad, 16383);
    check("mvx_after_start", bus.mv_x, 0);
    check("mvy_after_start", bus.mv_y, 0);
    for (int i = 1; i < SKIP; i++) begin
      gap(gapmax);
      drive(1'b0, 1'b1, '0);
    end
    for (int k = 0; k < SW * NC && !saw_done; k++) begin
      gap(gapmax);
      drive(1'b0, 1'b1, SADW'(sad_for(scen, k % SW, k / SW)));
      if (k == abort_at) return;
      if (k == probe_k) begin
        drive(1'b0, 1'b0, '0);
        check("update_latency", bus.min_sad, probe_min);
      end
    end
    drive(1'b0, 1'b0, '0);
    check("done_one_cycle", bus.done, 0);
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic check_result(input int exp_min, input int exp_x, input int exp_y,
                              input int exp_at, input int dc_before);
    check("done_seen", saw_done, 1);
    check("busy_at_done", snap_busy, 0);
    check("min_at_done", snap_min, exp_min);
    check("mvx_at_done", snap_x, exp_x);
    check("mvy_at_done", snap_y, exp_y);
    check("done_strobe_idx", done_at, exp_at);
    check("done_count", done_cnt - dc_before, 1);
  endtask

  int dc;
  int exp_at_zero;

  initial begin
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad       = '0;

    // Reset state.
    repeat (3) drive(1'b0, 1'b0, '0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_min", bus.min_sad, 16383);
    check("rst_mvx", bus.mv_x, 0);
    check("rst_mvy", bus.mv_y, 0);
    rst_n = 1'b1;

    // Idle strobes are ignored.
    repeat (5) drive(1'b0, 1'b1, SADW'(5));
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check("idle_min", bus.min_sad, 16383);
    check("idle_mvx", bus.mv_x, 0);
    check("idle_mvy", bus.mv_y, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_no_done", done_cnt, 0);

    // Single minimum at (3,5), k = 5*32+3 = 163.
    dc = done_cnt;
    run_pass(2, 0, -1, 1'b0, 163, 20);
    check_result(20, 3, 5, SKIP + NSRCH, dc);

    // Ties keep the earlier raster position; zeros in wrap columns ignored.
    dc = done_cnt;
    run_pass(3, 0, -1, 1'b0, -1, 0);
    check_result(50, 10, 2, SKIP + NSRCH, dc);
    repeat (3) drive(1'b0, 1'b1, SADW'(1));
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check("hold_min", bus.min_sad, 50);
    check("hold_mvx", bus.mv_x, 10);
    check("hold_mvy", bus.mv_y, 2);
    check("hold_no_done", done_cnt - dc, 1);

    // Random strobe gaps give the identical result.
    dc = done_cnt;
    run_pass(2, 3, -1, 1'b0, -1, 0);
    check_result(20, 3, 5, SKIP + NSRCH, dc);

    // Abort at search strobe 400 by a start carrying a coincident strobe.
    dc = done_cnt;
    run_pass(2, 0, 400, 1'b0, -1, 0);
    run_pass(3, 0, -1, 1'b1, -1, 0);
    check_result(50, 10, 2, SKIP + NSRCH, dc);

    // Reset mid-search.
    run_pass(2, 0, 300, 1'b0, -1, 0);
    drive(1'b0, 1'b0, '0);
    check("mid_min_before_rst", bus.min_sad, 20);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_min", bus.min_sad, 16383);
    check("mid_rst_mvx", bus.mv_x, 0);
    check("mid_rst_mvy", bus.mv_y, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);

    // Zero SAD at (4,4), k = 4*32+4 = 132.
`ifdef ZERO_SAD_STOP_EN
    exp_at_zero = SKIP + 4 * SW + 4 + 1;
`else
    exp_at_zero = SKIP + NSRCH;
`endif
    dc = done_cnt;
    run_pass(4, 0, -1, 1'b0, -1, 0);
    check_result(0, 4, 4, exp_at_zero, dc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sad_min_select.md
# sad_min_select

Motion-vector decision stage directly downstream of the PE array. It consumes the SAD value the array produces on each search-window shift, discards pipeline-fill and row-wrap candidates, and tracks the minimum SAD together with its candidate position. It reports the best motion vector with a one-cycle done pulse when the block-matching search finishes.

## Interface
- TB_LENGTH, 8: template block edge in pixels.
- SW_LENGTH, 32: search window edge in pixels.
- SAD_WIDTH, 14: SAD bit width.
- SKIP_CNT, 231: strobes discarded after start; equals SW_LENGTH*(TB_LENGTH-1)+TB_LENGTH-1 (array fill).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears state and begins a search.
- sad_valid  in  1  strobe; high when `sad` is a new array result (driven from en_sw, delay-aligned).
- sad  in  SAD_WIDTH  SAD from the PE array.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at search end.
- min_sad  out  SAD_WIDTH  best SAD so far.
- mv_x  out  MVW  column of best candidate; MVW = $clog2(SW_LENGTH-TB_LENGTH+1), 5 by default.
- mv_y  out  MVW  row of best candidate.

## Operation
- Define NC = SW_LENGTH-TB_LENGTH+1 (25 by default).
- States:
  - IDLE: wait for start; sad_valid is ignored.
  - SKIP: count SKIP_CNT strobes; values are discarded.
  - SEARCH: evaluate strobes.
  - IDLE is re-entered after done.
- On start in any state: min_sad = all ones; mv_x = mv_y = 0; x = y = skip counter = 0; go to SKIP. If SKIP_CNT = 0, go directly to SEARCH.
- SEARCH, per strobe:
  - The position (x, y) is a candidate only if x < NC.
  - Strobes with x >= NC are row-wrap garbage. They advance x and are never compared.
  - x wraps from SW_LENGTH-1 to 0 and increments y.
- Candidate update: if sad < min_sad (strict), load min_sad = sad, mv_x = x, mv_y = y. Ties keep the earlier raster position.
- The search ends on the strobe at (NC-1, NC-1), i.e. after NC*SW_LENGTH - (TB_LENGTH-1) search strobes (793 by default).
- After done, min_sad, mv_x and mv_y hold their values until the next start or reset.
- Strobe gaps (sad_valid low) freeze all counters. Results must not depend on gap pattern.
- Comparison is unsigned over the full SAD_WIDTH. Counters are sized to SW_LENGTH and SKIP_CNT with no overflow.

## Timing
- Reset values: busy=0, done=0, min_sad=2^SAD_WIDTH-1 (16383), mv_x=0, mv_y=0, state IDLE.
- Reset is honoured mid-search with no residual state.
- start sampled at edge N: busy=1 and min_sad reset visible after edge N.
- If start and sad_valid arrive in the same cycle, the strobe is discarded and not counted.
- Update latency: a candidate strobe sampled at edge N is reflected in min_sad/mv after edge N.
- done: the final strobe sampled at edge N gives done=1 and busy=0 after edge N, for exactly one cycle. Final min_sad/mv are valid in that same cycle.
- start while busy aborts and restarts with no done pulse. start in the cycle done is high is legal.

## Configuration
- ZERO_SAD_STOP_EN defined:
  - A candidate with sad == 0 completes the search immediately: done pulses one cycle after that strobe, and min_sad=0 with that position.
  - Remaining strobes are ignored until the next start.
- Not defined: the full candidate set is always scanned, and a zero SAD is treated as an ordinary minimum.

## Test plan
- Reset then idle strobes with sad=5 -> min_sad=16383, mv=(0,0), busy=0, done never asserted.
- start, 231 skip strobes with sad=0, then search with sad=100 everywhere except (3,5)=20 -> done after strobe 231+793, min_sad=20, mv=(3,5).
- Equal sad=50 at (10,2) and (1,7), others 60 -> mv=(10,2); sad=0 at x=28 (wrap columns) ignored -> min_sad unaffected.
- Same as scenario 2 with random sad_valid gaps of 0-3 cycles -> identical result and identical done strobe count.
- start asserted at search strobe 400, then a clean search -> one done only, result from the second pass. rst_n low mid-search -> all reset values.
- With ZERO_SAD_STOP_EN, sad=0 at (4,4) -> done right after that strobe, min_sad=0, mv=(4,4). Without the macro, the scan continues and done occurs at strobe 1024.
